// File: rtl/ct_mmu_pmp_chk.sv
// Per-port PMP check stage: registers a page address for PMP lookup, samples the
// returned permission flags and produces a fault verdict on a valid/ready channel.
module ct_mmu_pmp_chk #(
  parameter int PA_WIDTH = 28,
  parameter int ID_WIDTH = 4
) (
  input  logic                cpuclk,
  input  logic                cpurst,
  input  logic                flush,
  input  logic                cp0_pmp_wreg,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic [PA_WIDTH-1:0] req_pa,
  input  logic [1:0]          req_type,
  input  logic [ID_WIDTH-1:0] req_id,
  output logic [PA_WIDTH-1:0] mmu_pmp_pa,
  input  logic [3:0]          pmp_mmu_flg,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [ID_WIDTH-1:0] rsp_id,
  output logic [PA_WIDTH-1:0] rsp_pa,
  output logic [3:0]          rsp_flg,
  output logic                rsp_fault
);

  localparam logic [1:0] TYPE_STORE = 2'b01;
  localparam logic [1:0] TYPE_FETCH = 2'b10;

  logic                s1_vld;
  logic [PA_WIDTH-1:0] s1_pa;
  logic [1:0]          s1_type;
  logic [ID_WIDTH-1:0] s1_id;

  logic s1_adv;
  logic req_acc;
  logic fault_nxt;

  // A pending CSR write stalls S1 so the lookup is replayed against the new config.
  assign s1_adv  = s1_vld & ~cp0_pmp_wreg & (~rsp_vld | rsp_rdy);
  assign req_rdy = ~flush & (~s1_vld | s1_adv);
  assign req_acc = req_vld & req_rdy;

  assign mmu_pmp_pa = s1_pa;

  always_comb begin
    fault_nxt = ~pmp_mmu_flg[0];
    case (s1_type)
      TYPE_STORE: fault_nxt = ~pmp_mmu_flg[1];
      TYPE_FETCH: fault_nxt = ~pmp_mmu_flg[2];
      default:    fault_nxt = ~pmp_mmu_flg[0];
    endcase
  end

  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      s1_vld <= 1'b0;
    end else if (flush) begin
      s1_vld <= 1'b0;
    end else if (req_acc) begin
      s1_vld <= 1'b1;
    end else if (s1_adv) begin
      s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      s1_pa   <= '0;
      s1_type <= '0;
      s1_id   <= '0;
    end else if (req_acc) begin
      s1_pa   <= req_pa;
      s1_type <= req_type;
      s1_id   <= req_id;
    end
  end

  // Flush wins over advance; R data is only loaded on a real advance.
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      rsp_vld <= 1'b0;
    end else if (flush) begin
      rsp_vld <= 1'b0;
    end else if (s1_adv) begin
      rsp_vld <= 1'b1;
    end else if (rsp_rdy) begin
      rsp_vld <= 1'b0;
    end
  end

  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      rsp_id    <= '0;
      rsp_pa    <= '0;
      rsp_flg   <= '0;
      rsp_fault <= 1'b0;
    end else if (s1_adv && !flush) begin
      rsp_id    <= s1_id;
      rsp_pa    <= s1_pa;
      rsp_flg   <= pmp_mmu_flg;
      rsp_fault <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_ct_mmu_pmp_chk.sv
// Bench for ct_mmu_pmp_chk: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the requests in flight.
module tb_ct_mmu_pmp_chk;

  logic        cpuclk = 1'b0;
  logic        cpurst;
  logic        flush;
  logic        cp0_pmp_wreg;
  logic        req_vld;
  logic        req_rdy;
  logic [27:0] req_pa;
  logic [1:0]  req_type;
  logic [3:0]  req_id;
  logic [27:0] mmu_pmp_pa;
  logic [3:0]  pmp_mmu_flg;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [3:0]  rsp_id;
  logic [27:0] rsp_pa;
  logic [3:0]  rsp_flg;
  logic        rsp_fault;

  ct_mmu_pmp_chk #(.PA_WIDTH(28), .ID_WIDTH(4)) dut (
    .cpuclk(cpuclk), .cpurst(cpurst), .flush(flush), .cp0_pmp_wreg(cp0_pmp_wreg),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_pa(req_pa), .req_type(req_type),
    .req_id(req_id), .mmu_pmp_pa(mmu_pmp_pa), .pmp_mmu_flg(pmp_mmu_flg),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_pa(rsp_pa),
    .rsp_flg(rsp_flg), .rsp_fault(rsp_fault)
  );

  always #5 cpuclk = ~cpuclk;

  // Toy PMP: flags come from a config word, optionally mixed with the address.
  logic [3:0] cfg;
  logic [3:0] cfg_wr_val;
  logic       mix;

  function automatic logic [3:0] pmp_func(input logic [27:0] pa, input logic [3:0] c,
                                          input logic m);
    return m ? (c ^ pa[3:0] ^ pa[7:4]) : c;
  endfunction

  assign pmp_mmu_flg = pmp_func(mmu_pmp_pa, cfg, mix);

  typedef struct packed {
    logic [27:0] pa;
    logic [1:0]  typ;
    logic [3:0]  id;
    logic        smp;
    logic [3:0]  flg;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic expFault(input logic [1:0] t, input logic [3:0] f);
    if (t == 2'b01) return !f[1];
    if (t == 2'b10) return !f[2];
    return !f[0];
  endfunction

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic applyStimulus(input logic v, input logic [27:0] pa, input logic [1:0] t,
                               input logic [3:0] id, input logic rr, input logic wr,
                               input logic fl, output logic acc);
    ent_t e;
    int   n;
    bit   head_rsp, has_s1, adv, exp_rdy;
    @(negedge cpuclk);
    req_vld = v; req_pa = pa; req_type = t; req_id = id;
    rsp_rdy = rr; cp0_pmp_wreg = wr; flush = fl;
    #1;
    n        = q.size();
    head_rsp = (n > 0) && q[0].smp;
    has_s1   = (n > 0) && !q[n-1].smp;
    adv      = has_s1 && !wr && (!head_rsp || rr);
    exp_rdy  = !fl && (!has_s1 || adv);
    acc      = v && exp_rdy;
    checkOutput("req_rdy", {31'b0, req_rdy}, {31'b0, exp_rdy});
    checkOutput("rsp_vld", {31'b0, rsp_vld}, {31'b0, head_rsp});
    if (head_rsp) begin
      checkOutput("rsp_id", {28'b0, rsp_id}, {28'b0, q[0].id});
      checkOutput("rsp_pa", {4'b0, rsp_pa}, {4'b0, q[0].pa});
      checkOutput("rsp_flg", {28'b0, rsp_flg}, {28'b0, q[0].flg});
      checkOutput("rsp_fault", {31'b0, rsp_fault}, {31'b0, expFault(q[0].typ, q[0].flg)});
    end
    if (has_s1) checkOutput("mmu_pmp_pa", {4'b0, mmu_pmp_pa}, {4'b0, q[n-1].pa});
    @(posedge cpuclk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (head_rsp && rr) void'(q.pop_front());
      if (adv) begin
        e     = q[q.size()-1];
        e.smp = 1'b1;
        e.flg = pmp_func(e.pa, cfg, mix);
        q[q.size()-1] = e;
      end
      if (acc) begin
        e = '{pa: pa, typ: t, id: id, smp: 1'b0, flg: 4'b0};
        q.push_back(e);
      end
    end
    if (wr) cfg = cfg_wr_val;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 28'h0, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, a);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rsp_vld"}, {31'b0, rsp_vld}, 32'd0);
    checkOutput({tag, "_rsp_fault"}, {31'b0, rsp_fault}, 32'd0);
    checkOutput({tag, "_rsp_id"}, {28'b0, rsp_id}, 32'd0);
    checkOutput({tag, "_rsp_pa"}, {4'b0, rsp_pa}, 32'd0);
    checkOutput({tag, "_rsp_flg"}, {28'b0, rsp_flg}, 32'd0);
    checkOutput({tag, "_mmu_pmp_pa"}, {4'b0, mmu_pmp_pa}, 32'd0);
    checkOutput({tag, "_req_rdy"}, {31'b0, req_rdy}, 32'd1);
  endtask

  initial begin
    logic a;
    int   sent;
    cpurst = 1'b1; flush = 1'b0; cp0_pmp_wreg = 1'b0; req_vld = 1'b0;
    req_pa = '0; req_type = '0; req_id = '0; rsp_rdy = 1'b0;
    cfg = 4'h0; cfg_wr_val = 4'h0; mix = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(negedge cpuclk);
    cpurst = 1'b0;

    $display("[TB] single load");
    cfg = 4'b0001;
    applyStimulus(1'b1, 28'h0001234, 2'b00, 4'd3, 1'b1, 1'b0, 1'b0, a);
    checkOutput("single_accept", {31'b0, a}, 32'd1);
    idle(3);

    $display("[TB] fault per type");
    cfg = 4'b0101;
    applyStimulus(1'b1, 28'h0000010, 2'b01, 4'd1, 1'b1, 1'b0, 1'b0, a);
    applyStimulus(1'b1, 28'h0000020, 2'b10, 4'd2, 1'b1, 1'b0, 1'b0, a);
    applyStimulus(1'b1, 28'h0000030, 2'b11, 4'd3, 1'b1, 1'b0, 1'b0, a);
    idle(3);
    cfg = 4'b1000;
    for (int t = 0; t < 4; t++)
      applyStimulus(1'b1, 28'h0000100 + 28'(t), 2'(t), 4'(t + 4), 1'b1, 1'b0, 1'b0, a);
    idle(3);

    $display("[TB] streaming with backpressure");
    cfg = 4'b0111;
    sent = 0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      applyStimulus(1'b1, 28'h0002000 + 28'(sent), 2'(sent), 4'(sent),
                    !(c >= 3 && c < 6), 1'b0, 1'b0, a);
      if (a) sent++;
    end
    checkOutput("stream_sent", 32'(sent), 32'd8);
    idle(3);

    $display("[TB] replay on CSR write");
    cfg = 4'b0000; cfg_wr_val = 4'b0001;
    applyStimulus(1'b1, 28'h0003000, 2'b00, 4'd9, 1'b1, 1'b0, 1'b0, a);
    applyStimulus(1'b0, 28'h0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, a);
    applyStimulus(1'b0, 28'h0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, a);
    idle(3);

    $display("[TB] flush");
    cfg = 4'b0111;
    applyStimulus(1'b1, 28'h0004000, 2'b00, 4'd1, 1'b0, 1'b0, 1'b0, a);
    applyStimulus(1'b1, 28'h0004001, 2'b01, 4'd2, 1'b0, 1'b0, 1'b0, a);
    applyStimulus(1'b1, 28'h0004002, 2'b10, 4'd3, 1'b0, 1'b0, 1'b1, a);
    checkOutput("flush_no_accept", {31'b0, a}, 32'd0);
    idle(2);
    applyStimulus(1'b1, 28'h0004003, 2'b10, 4'd4, 1'b1, 1'b0, 1'b0, a);
    idle(3);

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 28'h0005000, 2'b00, 4'd5, 1'b0, 1'b0, 1'b0, a);
    applyStimulus(1'b1, 28'h0005001, 2'b00, 4'd6, 1'b0, 1'b0, 1'b0, a);
    checkOutput("pre_reset_in_flight", 32'(q.size()), 32'd2);
    req_vld = 1'b0; rsp_rdy = 1'b0; cp0_pmp_wreg = 1'b0; flush = 1'b0;
    #2 cpurst = 1'b1;
    #1;
    checkResetOutputs("async_reset");
    q.delete();
    @(negedge cpuclk);
    cpurst = 1'b0;
    #1;
    checkOutput("post_reset_req_rdy", {31'b0, req_rdy}, 32'd1);
    idle(2);

    $display("[TB] random traffic");
    mix = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cfg_wr_val = 4'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, 28'($urandom), 2'($urandom), 4'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 31) == 0, a);
    end
    idle(4);
    checkOutput("drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
